nco_2ch: RTL and testbench

Two-channel numerically controlled oscillator front end that drives the address ports of the team's 2-channel synchronous waveform ROM and collects its registered outputs. It steps a phase accumulator by a programmable tuning word and derives a second channel at a programmable phase offset, for example quadrature. Tuning updates are phase-continuous. It delivers aligned sample pairs with a valid strobe to the downstream sigma-delta modulators.

---
 rtl/nco_2ch_pkg.sv | 23 ++
 rtl/nco_phase_acc.sv | 88 ++++++++
 rtl/nco_2ch.sv | 109 ++++++++++
 tb/tb_nco_2ch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_2ch_pkg.sv
// Shared definitions for the two-channel NCO: default widths and the
// pending-update FSM encoding, guarded so the block can be pulled in more than once.
`ifndef NCO_2CH_DEFS_SVH
`define NCO_2CH_DEFS_SVH
`define NCO_ADDR_WIDTH  9
`define NCO_DATA_WIDTH  8
`define NCO_PHASE_WIDTH 24
`define NCO_ST_IDLE     1'b0
`define NCO_ST_PEND     1'b1
`endif

package nco_2ch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = `NCO_ADDR_WIDTH;
  localparam int unsigned DEF_DATA_WIDTH  = `NCO_DATA_WIDTH;
  localparam int unsigned DEF_PHASE_WIDTH = `NCO_PHASE_WIDTH;

  typedef enum logic {
    IDLE = `NCO_ST_IDLE,
    PEND = `NCO_ST_PEND
  } upd_state_t;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator with double-buffered tuning word and channel-B offset.
// A pending setting is applied on the carry step so frequency changes stay phase-continuous.
module nco_phase_acc
  import nco_2ch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [PHASE_WIDTH-1:0] i_ftw,
  input  logic [ADDR_WIDTH-1:0]  i_poff,
  output logic                   o_busy,
  output logic [ADDR_WIDTH-1:0]  o_phase,
  output logic [ADDR_WIDTH-1:0]  o_poff,
  output logic                   o_carry
);

  upd_state_t             state_r;
  logic [PHASE_WIDTH-1:0] acc_r;
  logic [PHASE_WIDTH-1:0] ftw_act_r;
  logic [PHASE_WIDTH-1:0] ftw_pend_r;
  logic [ADDR_WIDTH-1:0]  poff_act_r;
  logic [ADDR_WIDTH-1:0]  poff_pend_r;
  logic                   carry_r;
  logic [PHASE_WIDTH:0]   sum_s;
  logic                   apply_s;
  logic [ADDR_WIDTH-1:0]  poff_eff_s;

  // Next phase, apply decision; a zero word also applies so a fresh reset cannot deadlock.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, ftw_act_r};
    apply_s    = 1'b0;
    poff_eff_s = poff_act_r;
    if (i_en && (state_r == PEND) &&
        (sum_s[PHASE_WIDTH] || (ftw_act_r == {PHASE_WIDTH{1'b0}}))) begin
      apply_s    = 1'b1;
      poff_eff_s = poff_pend_r;
    end else begin
      apply_s    = 1'b0;
      poff_eff_s = poff_act_r;
    end
  end

  // Accumulator and its carry flag advance only on enabled cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r   <= {PHASE_WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (i_en) begin
      acc_r   <= sum_s[PHASE_WIDTH-1:0];
      carry_r <= sum_s[PHASE_WIDTH];
    end
  end

  // Pending-update FSM; an apply reads the old pending value even when a load lands alongside.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      ftw_act_r   <= {PHASE_WIDTH{1'b0}};
      ftw_pend_r  <= {PHASE_WIDTH{1'b0}};
      poff_act_r  <= {ADDR_WIDTH{1'b0}};
      poff_pend_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (apply_s) begin
        ftw_act_r  <= ftw_pend_r;
        poff_act_r <= poff_pend_r;
      end
      if (i_load) begin
        ftw_pend_r  <= i_ftw;
        poff_pend_r <= i_poff;
      end
      case (state_r)
        IDLE: if (i_load) state_r <= PEND;
        PEND: if (apply_s && !i_load) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state_r == PEND);
  assign o_phase = acc_r[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign o_poff  = poff_eff_s;
  assign o_carry = carry_r;

endmodule

// File: rtl/nco_2ch.sv
// Two-channel NCO front end: issues ROM addresses from the phase accumulator and
// collects the ROM's registered words into aligned, valid-strobed sample pairs.
module nco_2ch
  import nco_2ch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [PHASE_WIDTH-1:0] i_ftw,
  input  logic [ADDR_WIDTH-1:0]  i_poff,
  output logic                   o_busy,
  output logic                   o_rom_en,
  output logic [ADDR_WIDTH-1:0]  o_addr_a,
  output logic [ADDR_WIDTH-1:0]  o_addr_b,
  input  logic [DATA_WIDTH-1:0]  i_rom_data_a,
  input  logic [DATA_WIDTH-1:0]  i_rom_data_b,
  output logic [DATA_WIDTH-1:0]  o_data_a,
  output logic [DATA_WIDTH-1:0]  o_data_b,
  output logic                   o_valid,
  output logic                   o_wrap
);

  logic [ADDR_WIDTH-1:0] phase_s;
  logic [ADDR_WIDTH-1:0] poff_s;
  logic                  carry_s;
  logic                  busy_s;
  logic                  rom_en_r;
  logic [ADDR_WIDTH-1:0] addr_a_r;
  logic [ADDR_WIDTH-1:0] addr_b_r;
  logic                  v1_r;
  logic                  w1_r;
  logic                  v2_r;
  logic                  w2_r;
  logic                  valid_r;
  logic                  wrap_r;
  logic [DATA_WIDTH-1:0] data_a_r;
  logic [DATA_WIDTH-1:0] data_b_r;

  nco_phase_acc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PHASE_WIDTH(PHASE_WIDTH)
  ) u_phase_acc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .i_load (i_load),
    .i_ftw  (i_ftw),
    .i_poff (i_poff),
    .o_busy (busy_s),
    .o_phase(phase_s),
    .o_poff (poff_s),
    .o_carry(carry_s)
  );

  // Address issue stage; the wrap mark rides with the first address past a carry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_en_r <= 1'b0;
      addr_a_r <= {ADDR_WIDTH{1'b0}};
      addr_b_r <= {ADDR_WIDTH{1'b0}};
      v1_r     <= 1'b0;
      w1_r     <= 1'b0;
    end else begin
      rom_en_r <= 1'b1;
      v1_r     <= i_en;
      w1_r     <= i_en & carry_s;
      if (i_en) begin
        addr_a_r <= phase_s;
        addr_b_r <= phase_s + poff_s;
      end
    end
  end

  // ROM-latency stage and output capture, gated by the tracked valid pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2_r     <= 1'b0;
      w2_r     <= 1'b0;
      valid_r  <= 1'b0;
      wrap_r   <= 1'b0;
      data_a_r <= {DATA_WIDTH{1'b0}};
      data_b_r <= {DATA_WIDTH{1'b0}};
    end else begin
      v2_r    <= v1_r;
      w2_r    <= w1_r;
      valid_r <= v2_r;
      wrap_r  <= v2_r & w2_r;
      if (v2_r) begin
        data_a_r <= i_rom_data_a;
        data_b_r <= i_rom_data_b;
      end
    end
  end

  assign o_busy   = busy_s;
  assign o_rom_en = rom_en_r;
  assign o_addr_a = addr_a_r;
  assign o_addr_b = addr_b_r;
  assign o_data_a = data_a_r;
  assign o_data_b = data_b_r;
  assign o_valid  = valid_r;
  assign o_wrap   = wrap_r;

endmodule

// File: tb/tb_nco_2ch.sv
// Bench for nco_2ch: directed scenarios plus random traffic, an unbounded-phase
// reference model, and a queue scoreboard checked by an independent output monitor.
module tb_nco_2ch;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int PW = 24;

  logic          clk;
  logic          rst_n;
  logic          i_en;
  logic          i_load;
  logic [PW-1:0] i_ftw;
  logic [AW-1:0] i_poff;
  logic          o_busy;
  logic          o_rom_en;
  logic [AW-1:0] o_addr_a;
  logic [AW-1:0] o_addr_b;
  logic [DW-1:0] rom_a;
  logic [DW-1:0] rom_b;
  logic [DW-1:0] o_data_a;
  logic [DW-1:0] o_data_b;
  logic          o_valid;
  logic          o_wrap;

  nco_2ch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (i_en),
    .i_load      (i_load),
    .i_ftw       (i_ftw),
    .i_poff      (i_poff),
    .o_busy      (o_busy),
    .o_rom_en    (o_rom_en),
    .o_addr_a    (o_addr_a),
    .o_addr_b    (o_addr_b),
    .i_rom_data_a(rom_a),
    .i_rom_data_b(rom_b),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_valid     (o_valid),
    .o_wrap      (o_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2-channel ROM, 1-cycle registered read, mem[i] = i[7:0].
  logic [DW-1:0] mem [0:511];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = i[7:0];
    rom_a = 8'h00;
    rom_b = 8'h00;
  end
  always @(posedge clk) begin
    if (o_rom_en) begin
      rom_a <= mem[o_addr_a];
      rom_b <= mem[o_addr_b];
    end
  end

  typedef struct {
    int a;
    int b;
    bit w;
    int issue;
  } samp_t;

  samp_t  q[$];
  samp_t  s;
  bit     exp_now;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     wrap_cnt = 0;
  int     last_wrap_data = -1;

  longint m_total;
  int     m_ftw_act, m_ftw_pend, m_poff_act, m_poff_pend;
  bit     m_pend, m_carried;
  int     m_addr_a, m_addr_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_total = 0;
    m_ftw_act = 0; m_ftw_pend = 0; m_poff_act = 0; m_poff_pend = 0;
    m_pend = 1'b0; m_carried = 1'b0;
    m_addr_a = 0; m_addr_b = 0;
  endtask

  // Phase is kept as an unbounded sum; a carry is a crossing of a 2^24 boundary.
  task automatic model_edge(input bit en, input bit ld, input logic [23:0] f, input logic [8:0] p);
    longint nxt;
    bit     crossed;
    bit     apply;
    int     pe;
    if (en) begin
      nxt      = m_total + longint'(m_ftw_act);
      crossed  = (nxt >> 24) != (m_total >> 24);
      apply    = m_pend && (crossed || m_ftw_act == 0);
      pe       = apply ? m_poff_pend : m_poff_act;
      m_addr_a = int'((m_total >> 15) & 64'd511);
      m_addr_b = (m_addr_a + pe) % 512;
      q.push_back('{a: m_addr_a, b: m_addr_b, w: m_carried, issue: cyc + 1});
      m_carried = crossed;
      m_total   = nxt;
      if (apply) begin
        m_ftw_act  = m_ftw_pend;
        m_poff_act = m_poff_pend;
        m_pend     = 1'b0;
      end
    end
    if (ld) begin
      m_ftw_pend  = int'(f);
      m_poff_pend = int'(p);
      m_pend      = 1'b1;
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [23:0] f, input logic [8:0] p);
    i_en = en; i_load = ld; i_ftw = f; i_poff = p;
    model_edge(en, ld, f, p);
    @(posedge clk);
    cyc++;
    #1;
    chk("addr_a", 32'(o_addr_a), m_addr_a);
    chk("addr_b", 32'(o_addr_b), m_addr_b);
    chk("busy", 32'(o_busy), 32'(m_pend));
    chk("rom_en", 32'(o_rom_en), 32'd1);
  endtask

  task automatic run_en(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 24'h0, 9'h0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_addr_a"}, 32'(o_addr_a), 32'd0);
    chk({name, "_addr_b"}, 32'(o_addr_b), 32'd0);
    chk({name, "_data_a"}, 32'(o_data_a), 32'd0);
    chk({name, "_data_b"}, 32'(o_data_b), 32'd0);
    chk({name, "_valid"}, 32'(o_valid), 32'd0);
    chk({name, "_wrap"}, 32'(o_wrap), 32'd0);
    chk({name, "_busy"}, 32'(o_busy), 32'd0);
    chk({name, "_rom_en"}, 32'(o_rom_en), 32'd0);
  endtask

  task automatic run_sc1();
    logic [8:0] ea [3];
    logic [8:0] eb [3];
    ea = '{9'h000, 9'h000, 9'h001};
    eb = '{9'h080, 9'h080, 9'h081};
    step(1'b0, 1'b1, 24'h008000, 9'h080);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 24'h0, 9'h0);
      chk("sc1_addr_a", 32'(o_addr_a), 32'(ea[k]));
      chk("sc1_addr_b", 32'(o_addr_b), 32'(eb[k]));
    end
  endtask

  // Monitor: a pair must appear exactly 2 edges after its issue, never otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].issue + 2 < cyc) void'(q.pop_front());
      exp_now = (q.size() > 0) && (q[0].issue + 2 == cyc);
      chk("valid", 32'(o_valid), 32'(exp_now));
      if (o_valid && exp_now) begin
        s = q.pop_front();
        chk("data_a", 32'(o_data_a), s.a & 32'hFF);
        chk("data_b", 32'(o_data_b), s.b & 32'hFF);
        chk("wrap", 32'(o_wrap), 32'(s.w));
      end
      if (o_valid && o_wrap) begin
        wrap_cnt++;
        last_wrap_data = int'(o_data_a);
      end
      if (!o_valid) chk("wrap_no_valid", 32'(o_wrap), 32'd0);
    end
  end

  bit            r_en, r_ld;
  logic [23:0]   r_f;
  logic [8:0]    r_p;
  logic [AW-1:0] hold_a;
  int            base, n;

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_load = 1'b0; i_ftw = 24'h0; i_poff = 9'h0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 24'h0, 9'h0);

    run_sc1();

    // Run through the first wrap with a 3-cycle enable gap partway.
    base = wrap_cnt;
    run_en(200);
    hold_a = o_addr_a;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 24'h0, 9'h0);
      chk("gap_hold_a", 32'(o_addr_a), 32'(hold_a));
    end
    run_en(320);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 24'h0, 9'h0);
    chk("sc2_wrap_count", wrap_cnt - base, 32'd1);
    chk("sc2_wrap_sample", last_wrap_data, 32'd0);

    step(1'b1, 1'b1, 24'h010000, 9'h080);
    n = 0;
    while (o_busy && n < 600) begin
      step(1'b1, 1'b0, 24'h0, 9'h0);
      n++;
    end
    chk("sc3_applied", 32'(o_busy), 32'd0);
    chk("sc3_apply_addr", 32'(o_addr_a), 32'h1FF);
    step(1'b1, 1'b0, 24'h0, 9'h0);
    chk("sc3_after_wrap0", 32'(o_addr_a), 32'h000);
    step(1'b1, 1'b0, 24'h0, 9'h0);
    chk("sc3_after_wrap1", 32'(o_addr_a), 32'h002);

    step(1'b1, 1'b1, 24'h010000, 9'h040);
    step(1'b1, 1'b0, 24'h0, 9'h0);
    step(1'b1, 1'b1, 24'h010000, 9'h100);
    n = 0;
    while (o_busy && n < 300) begin
      step(1'b1, 1'b0, 24'h0, 9'h0);
      n++;
    end
    chk("sc4_applied", 32'(o_busy), 32'd0);
    step(1'b1, 1'b0, 24'h0, 9'h0);
    chk("sc4_offset", 32'(9'(o_addr_b - o_addr_a)), 32'h100);

    for (int k = 0; k < 1500; k++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_ld = ($urandom_range(0, 29) == 0);
      r_f  = 24'($urandom_range(32'h100, 32'h3FFFFF));
      r_p  = 9'($urandom_range(0, 511));
      step(r_en, r_ld, r_f, r_p);
    end

    // Asynchronous reset pulse between edges, then repeat the start-up scenario.
    rst_n = 1'b0; i_en = 1'b0; i_load = 1'b0;
    model_reset();
    #2;
    check_zero("rst_pulse");
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 24'h0, 9'h0);
    run_sc1();
    run_en(10);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 24'h0, 9'h0);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
